// File: rtl/boa_pkg.sv
// Shared types for the BOA CSR arbiter: write modes, privilege levels and
// sequencer states.
package boa_pkg;

    typedef enum logic [1:0] {
        CSR_RD = 2'b00,
        CSR_W  = 2'b01,
        CSR_S  = 2'b10,
        CSR_C  = 2'b11
    } csr_wmode_t;

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } arb_state_t;

    // A set/clear with an empty mask leaves the CSR untouched, so it is a read.
    function automatic logic wmode_dowrite(input csr_wmode_t wmode, input logic [31:0] wmask);
        return (wmode == CSR_W) || ((wmode == CSR_S || wmode == CSR_C) && (wmask != '0));
    endfunction

endpackage

// File: rtl/boa_csrw_helper.sv
// New CSR value from the old value, the write mode and the write data/mask.
module boa_csrw_helper
    import boa_pkg::*;
(
    input  csr_wmode_t  i_wmode,
    input  logic [31:0] i_old,
    input  logic [31:0] i_wmask,
    output logic [31:0] o_wdata
);

    always_comb begin
        // NOTE: assign a default before the case so no path can infer a latch.
        o_wdata = i_old;
        case (i_wmode)
            CSR_W:   o_wdata = i_wmask;
            CSR_S:   o_wdata = i_old | i_wmask;
            CSR_C:   o_wdata = i_old & ~i_wmask;
            default: o_wdata = i_old;
        endcase
    end

endmodule

// File: rtl/boa_rr_pick.sv
// Round-robin pick: first requesting index after i_last, wrapping modulo NREQ.
module boa_rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [IW-1:0]   o_grant,
    output logic            o_valid
);

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    // Offset NREQ comes last so the previous winner only wins when alone.
    always_comb begin
        o_grant = i_last;
        o_valid = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!o_valid && i_req[wrap_idx(i_last, k)]) begin
                o_grant = wrap_idx(i_last, k);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/boa_csr_arb.sv
// Round-robin arbiter and READ/WRITE sequencer sharing one CSR port between
// NREQ requesters, with exists/privilege/read-only legality checking.
module boa_csr_arb
    import boa_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0][1:0]  req_wmode,
    input  logic [NREQ-1:0][11:0] req_addr,
    input  logic [NREQ-1:0][31:0] req_wmask,
    input  logic [NREQ-1:0][1:0]  req_priv,
    output logic [NREQ-1:0]       ack,
    output logic                  err,
    output logic [31:0]           rdata,
    output logic                  busy,
    output logic                  csr_we,
    output logic [11:0]           csr_addr,
    output logic [31:0]           csr_wdata,
    input  logic                  csr_exists,
    input  logic                  csr_rdonly,
    input  logic [1:0]            csr_priv,
    input  logic [31:0]           csr_rdata
);

    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    arb_state_t      r_state;
    logic [IW-1:0]   r_last;
    logic [IW-1:0]   r_grant;
    csr_wmode_t      r_wmode;
    logic [31:0]     r_wmask;
    logic [1:0]      r_priv;
    logic [31:0]     r_old;
    logic [NREQ-1:0] r_ack;
    logic            r_err;
    logic [31:0]     r_rdata;
    logic            r_csr_we;
    logic [11:0]     r_csr_addr;
    logic [31:0]     r_csr_wdata;

    logic [IW-1:0]   w_pick;
    logic            w_pick_valid;
    logic            w_dowrite;
    logic            w_err;
    logic [31:0]     w_wdata;

    boa_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .i_req   (req),
        .i_last  (r_last),
        .o_grant (w_pick),
        .o_valid (w_pick_valid)
    );

    // Old value comes straight off the port during READ; it is latched at the READ edge.
    boa_csrw_helper u_wdata (
        .i_wmode (r_wmode),
        .i_old   (csr_rdata),
        .i_wmask (r_wmask),
        .o_wdata (w_wdata)
    );

    assign w_dowrite = wmode_dowrite(r_wmode, r_wmask);
    assign w_err     = !csr_exists || (r_priv < csr_priv) || (w_dowrite && csr_rdonly);

    // NOTE: request fields and the old value are always written before being
    // read, so they carry no reset and sit in their own flop block.
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && w_pick_valid) begin
            r_grant <= w_pick;
            r_wmode <= csr_wmode_t'(req_wmode[w_pick]);
            r_wmask <= req_wmask[w_pick];
            r_priv  <= req_priv[w_pick];
        end
        if (r_state == ST_READ) begin
            r_old <= csr_rdata;
        end
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_last      <= IW'(NREQ - 1);
            r_ack       <= '0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_csr_we    <= 1'b0;
            r_csr_addr  <= '0;
            r_csr_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_last     <= w_pick;
                        r_csr_addr <= req_addr[w_pick];
                        r_state    <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_err <= w_err;
                    if (w_dowrite && !w_err) begin
                        r_csr_we    <= 1'b1;
                        r_csr_wdata <= w_wdata;
                        r_state     <= ST_WRITE;
                    end else begin
                        r_ack   <= ONE << r_grant;
                        r_rdata <= w_err ? '0 : csr_rdata;
                        r_state <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    r_csr_we <= 1'b0;
                    r_ack    <= ONE << r_grant;
                    r_rdata  <= r_old;
                    r_state  <= ST_RESP;
                end
                default: begin
                    r_ack   <= '0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign busy      = (r_state != ST_IDLE);
    assign csr_we    = r_csr_we;
    assign csr_addr  = r_csr_addr;
    assign csr_wdata = r_csr_wdata;

endmodule

// File: tb/tb_boa_csr_arb.sv
// Scoreboard bench for boa_csr_arb: a small CSR table answers the port, each
// request pushes its expected response, the monitor pops it on ack.
module tb_boa_csr_arb;

    localparam int NREQ = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0][1:0]  req_wmode;
    logic [NREQ-1:0][11:0] req_addr;
    logic [NREQ-1:0][31:0] req_wmask;
    logic [NREQ-1:0][1:0]  req_priv;
    logic [NREQ-1:0]       ack;
    logic                  err;
    logic [31:0]           rdata;
    logic                  busy;
    logic                  csr_we;
    logic [11:0]           csr_addr;
    logic [31:0]           csr_wdata;
    logic                  csr_exists;
    logic                  csr_rdonly;
    logic [1:0]            csr_priv;
    logic [31:0]           csr_rdata;

    boa_csr_arb #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_wmode  (req_wmode),
        .req_addr   (req_addr),
        .req_wmask  (req_wmask),
        .req_priv   (req_priv),
        .ack        (ack),
        .err        (err),
        .rdata      (rdata),
        .busy       (busy),
        .csr_we     (csr_we),
        .csr_addr   (csr_addr),
        .csr_wdata  (csr_wdata),
        .csr_exists (csr_exists),
        .csr_rdonly (csr_rdonly),
        .csr_priv   (csr_priv),
        .csr_rdata  (csr_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        exists;
        logic        ro;
        logic [1:0]  priv;
        logic [31:0] val;
    } csr_ent_t;

    typedef struct {
        int          idx;
        logic        err;
        logic [31:0] rdata;
        int          nwr;
        logic [11:0] addr;
        logic [31:0] wdata;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   rise_cyc = 0;
    int   last_ack_cyc = 0;
    int   wr_seen  = 0;
    int   cont_acks = 0;
    bit   contention = 0;
    logic prev_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Fixed CSR table; anything not listed does not exist.
    function automatic csr_ent_t csr_tbl(input logic [11:0] a);
        case (a)
            12'h300: return '{1'b1, 1'b0, 2'd3, 32'h0000_1888};
            12'h304: return '{1'b1, 1'b0, 2'd3, 32'h0000_0008};
            12'h340: return '{1'b1, 1'b0, 2'd3, 32'hCAFE_0340};
            12'hF14: return '{1'b1, 1'b1, 2'd3, 32'h0000_0005};
            12'h100: return '{1'b1, 1'b0, 2'd1, 32'h0000_0022};
            default: return '{1'b0, 1'b0, 2'd0, 32'hDEAD_BEEF};
        endcase
    endfunction

    always_comb begin
        csr_exists = csr_tbl(csr_addr).exists;
        csr_rdonly = csr_tbl(csr_addr).ro;
        csr_priv   = csr_tbl(csr_addr).priv;
        csr_rdata  = csr_tbl(csr_addr).val;
    end

    function automatic exp_t model(input int idx, input logic [1:0] wm, input logic [11:0] a,
                                   input logic [31:0] m, input logic [1:0] p);
        exp_t     e;
        csr_ent_t c;
        logic     dw;
        c       = csr_tbl(a);
        dw      = (wm == 2'b01) || (wm[1] && m != 32'h0);
        e.idx   = idx;
        e.addr  = a;
        e.err   = !c.exists || (p < c.priv) || (dw && c.ro);
        e.nwr   = (dw && !e.err) ? 1 : 0;
        e.rdata = e.err ? 32'h0 : c.val;
        e.wdata = (wm == 2'b01) ? m : (wm == 2'b10) ? (c.val | m) : (c.val & ~m);
        e.lat   = (e.nwr == 1) ? 4 : 3;
        return e;
    endfunction

    // Latency counts inclusively from the IDLE cycle that grants to the ack cycle.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (busy && !prev_busy) begin
                rise_cyc = cyc;
                wr_seen  = 0;
                if (contention && cont_acks > 0)
                    check("idle_between_grants", 32'(cyc - last_ack_cyc - 1), 32'd1);
            end
            if (csr_we) begin
                wr_seen++;
                if (exp_q.size() > 0) begin
                    check("wr_addr", {20'h0, csr_addr}, {20'h0, exp_q[0].addr});
                    check("wr_data", csr_wdata, exp_q[0].wdata);
                end else begin
                    check("spurious_we", 32'd1, 32'd0);
                end
            end
            if (ack != '0) begin
                if (exp_q.size() == 0) begin
                    check("spurious_ack", 32'(ack), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ack_vec", 32'(ack), 32'(1) << e.idx);
                    check("err", {31'h0, err}, {31'h0, e.err});
                    check("rdata", rdata, e.rdata);
                    check("nwrites", 32'(wr_seen), 32'(e.nwr));
                    check("latency", 32'(cyc - rise_cyc + 2), 32'(e.lat));
                end
                last_ack_cyc = cyc;
                if (contention) cont_acks++;
            end
        end
        prev_busy = busy;
    end

    task automatic reset_dut();
        rst_n = 1'b0;
        req   = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_txn(input int idx, input logic [1:0] wm, input logic [11:0] a,
                           input logic [31:0] m, input logic [1:0] p, input bit drop_early);
        bit got;
        got = 0;
        @(posedge clk);
        #1;
        req_wmode[idx] = wm;
        req_addr[idx]  = a;
        req_wmask[idx] = m;
        req_priv[idx]  = p;
        exp_q.push_back(model(idx, wm, a, m, p));
        req[idx] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (drop_early && busy && req[idx]) begin
                req[idx]       = 1'b0;
                req_wmode[idx] = ~wm;
                req_addr[idx]  = 12'h7FF;
                req_wmask[idx] = ~m;
                req_priv[idx]  = 2'd0;
            end
            if (ack[idx]) begin
                got = 1;
                break;
            end
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 req[idx] = 1'b0;
    endtask

    initial begin
        bit got;
        int n;
        req       = '0;
        req_wmode = '0;
        req_addr  = '0;
        req_wmask = '0;
        req_priv  = '0;
        reset_dut();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", {31'h0, err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_we", {31'h0, csr_we}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_addr", {20'h0, csr_addr}, 32'd0);
        check("rst_wdata", csr_wdata, 32'd0);
        rst_n = 1'b1;

        run_txn(0, 2'b00, 12'h300, 32'h0,      2'd3, 0);
        run_txn(1, 2'b10, 12'h304, 32'h80,     2'd3, 0);
        run_txn(0, 2'b01, 12'hF14, 32'h1,      2'd3, 0);
        run_txn(1, 2'b11, 12'hF14, 32'h0,      2'd3, 0);
        run_txn(0, 2'b10, 12'hF14, 32'h0,      2'd3, 0);
        run_txn(1, 2'b00, 12'h300, 32'h0,      2'd0, 0);
        run_txn(0, 2'b00, 12'h7FF, 32'h0,      2'd3, 0);
        run_txn(1, 2'b01, 12'h300, 32'h1,      2'd0, 0);
        run_txn(0, 2'b01, 12'h340, 32'h1234,   2'd3, 1);
        run_txn(1, 2'b11, 12'h340, 32'hFF,     2'd3, 0);
        run_txn(0, 2'b00, 12'h100, 32'h0,      2'd1, 0);
        run_txn(1, 2'b10, 12'h100, 32'h1,      2'd0, 0);

        // Contention straight after reset: grants must alternate starting at 0.
        reset_dut();
        @(posedge clk);
        #1;
        req_wmode = '0;
        req_addr[0] = 12'h300;
        req_addr[1] = 12'h340;
        req_wmask = '0;
        req_priv[0] = 2'd3;
        req_priv[1] = 2'd3;
        for (int k = 0; k < 6; k++)
            exp_q.push_back(model(k % 2, 2'b00, (k % 2 == 0) ? 12'h300 : 12'h340, 32'h0, 2'd3));
        contention = 1;
        req = 2'b11;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ack != '0) n++;
            if (n == 6) break;
        end
        check("contention_acks", 32'(n), 32'd6);
        @(posedge clk);
        #1 req = '0;
        contention = 0;
        repeat (3) @(posedge clk);

        // Reset asserted during WRITE aborts the sequence.
        #1;
        req_wmode[0] = 2'b10;
        req_addr[0]  = 12'h304;
        req_wmask[0] = 32'h80;
        req_priv[0]  = 2'd3;
        exp_q.push_back(model(0, 2'b10, 12'h304, 32'h80, 2'd3));
        req[0] = 1'b1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (csr_we) begin
                got = 1;
                break;
            end
        end
        check("write_reached", {31'h0, got}, 32'd1);
        rst_n  = 1'b0;
        req[0] = 1'b0;
        @(negedge clk);
        check("abort_we", {31'h0, csr_we}, 32'd0);
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_busy", {31'h0, busy}, 32'd0);
        exp_q.delete();
        rst_n = 1'b1;
        run_txn(0, 2'b00, 12'h300, 32'h0, 2'd3, 0);
        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/boa_csr_arb.md
Name: boa_csr_arb

Overview:
- Round-robin arbiter and read-modify-write sequencer that shares one 0-latency CSR access port between NREQ requesters, e.g. pipeline CSR stage and debug module.
- Each granted request runs a fixed READ then optional WRITE sequence on the CSR port.
- Checks exists, privilege and read-only legality, and returns the old CSR value with ack/err.
- Sits between requesters and the CSR overlay's CPU-side port.

Parameters:
- NREQ, 2, number of requester ports (≥1).
- IW, $clog2(NREQ) (min 1), requester index width, derived.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  NREQ  request valid per requester; held with fields until ack.
- req_wmode  in  NREQ×2  00 read, 01 write, 10 set, 11 clear.
- req_addr  in  NREQ×12  CSR address.
- req_wmask  in  NREQ×32  write data / bit mask.
- req_priv  in  NREQ×2  requester privilege level.
- ack  out  NREQ  one-cycle completion pulse to granted requester.
- err  out  1  access illegal; valid with ack.
- rdata  out  32  old CSR value; valid with ack, 0 if err.
- busy  out  1  sequence in progress (state ≠ IDLE).
- csr_we  out  1  CSR write enable.
- csr_addr  out  12  CSR address.
- csr_wdata  out  32  CSR write data.
- csr_exists  in  1  CSR exists.
- csr_rdonly  in  1  CSR read-only.
- csr_priv  in  2  CSR minimum privilege.
- csr_rdata  in  32  CSR read data (same-cycle).

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, ack=0, err=0, rdata=0, csr_we=0.
  - csr_addr=0, csr_wdata=0, last-grant pointer=NREQ-1.
  - A reset mid-sequence aborts it: no write is issued, no ack is given.
- States: IDLE → READ → (WRITE) → RESP → IDLE.
- IDLE, any req set:
  - grant the first set index after the last grant, wrapping modulo NREQ; update the pointer.
  - latch grant index, wmode, addr, wmask, priv; go to READ.
  - no req set: stay in IDLE.
- READ:
  - csr_addr=latched addr, csr_we=0; latch csr_rdata as old value.
  - err computed as: !csr_exists OR priv<csr_priv (unsigned compare) OR (dowrite AND csr_rdonly).
  - dowrite = wmode==01 OR (wmode∈{10,11} AND wmask≠0). A set/clear with zero mask is a pure read and never raises a read-only error.
  - go to WRITE if dowrite AND !err, else go to RESP.
- WRITE:
  - csr_we=1, csr_addr=latched addr.
  - csr_wdata: 01 → wmask; 10 → old|wmask; 11 → old&~wmask.
  - go to RESP.
- RESP:
  - ack[grant]=1 for exactly this cycle; err as computed; rdata=old value (0 if err).
  - go to IDLE.
- Latency: 3 cycles from grant to ack for reads/errors, 4 for writes. Back-to-back grants are separated by one IDLE cycle.
- csr_we is asserted only in WRITE and is never asserted on err.
- csr_addr/csr_wdata are don't-care outside READ/WRITE, but stable registers.
- Requester changing its fields after grant: ignored (latched values used).
- req dropped mid-sequence: the sequence completes and ack still pulses.
- Simultaneous requests resolve strictly round-robin; a continuously requesting port is served at least every NREQ grants.

Decomposition:
- Shared package boa_pkg:
  - typedef enum logic[1:0] csr_wmode_t (CSR_RD, CSR_W, CSR_S, CSR_C).
  - privilege constants PRIV_U=0, PRIV_S=1, PRIV_M=3.
- Sub-modules:
  - Reuse boa_csrw_helper for wdata generation.
  - New boa_rr_pick (NREQ req vector + last index → grant index + valid) is a natural standalone sub-module.

Test Plan:
- Single read: req0, wmode 00, addr 0x300, priv 3, CSR rdata 0x1888 → ack0 at grant+3, rdata 0x1888, err 0, csr_we never 1.
- Set: req1, wmode 10, addr 0x304, wmask 0x80, old 0x08 → csr_we pulse with wdata 0x88, ack1 at grant+4, rdata 0x08.
- Read-only fault: wmode 01 to 0xF14 (rdonly=1) → err 1, rdata 0, no csr_we. Same CSR with wmode 11, wmask 0 → err 0.
- Privilege fault: req_priv 0, csr_priv 3 → err 1, no write. Nonexistent addr 0x7FF with csr_exists 0 → err 1.
- Contention: req0 and req1 held high for 6 transactions → grants alternate 0,1,0,1,… starting at 0 after reset; one IDLE cycle between.
- Reset during WRITE: rst_n low in WRITE cycle → next cycle csr_we 0, ack 0, busy 0; a new req0 afterwards is granted normally.
